// File: rtl/flash_bus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : flash_bus_sequencer
//  Description : Two-port round-robin arbiter and command sequencer for the
//                flash core bus. Each granted request runs the unlock,
//                opcode and access byte slots with every strobe edge placed
//                on a clk-counted phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module flash_bus_sequencer #(
  parameter int T_CMD   = 20,
  parameter int T_SETUP = 10,
  parameter int T_HOLD  = 7,
  parameter int T_DELTA = 1
) (
  input  logic        clk,
  input  logic        bi_rst,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        nEN,
  output logic        nRE,
  output logic        nWE,
  output logic [15:0] Addr,
  inout  wire  [7:0]  IO
);

  // Phase counter covers one byte slot of 2*T_CMD cycles.
  localparam int             c_KW        = $clog2(2 * T_CMD);
  localparam logic [c_KW-1:0] c_K_LAST   = c_KW'(2 * T_CMD - 1);
  localparam logic [c_KW-1:0] c_K_STB_ON = c_KW'(T_DELTA);
  localparam logic [c_KW-1:0] c_K_OE_ON  = c_KW'(T_CMD - T_SETUP);
  localparam logic [c_KW-1:0] c_K_CMD    = c_KW'(T_CMD);
  localparam logic [c_KW-1:0] c_K_EN_OFF = c_KW'(T_CMD + T_DELTA);
  localparam logic [c_KW-1:0] c_K_OE_OFF = c_KW'(T_CMD + T_HOLD);
  localparam logic [c_KW-1:0] c_K_RE_OFF = c_KW'(T_CMD - T_DELTA);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_UNLOCK1 = 3'd1,
    ST_UNLOCK2 = 3'd2,
    ST_OPCODE  = 3'd3,
    ST_ACCESS  = 3'd4,
    ST_FINISH  = 3'd5
  } state_t;

  state_t          r_state;
  logic [c_KW-1:0] r_k;
  logic            r_prio;     // port that wins a simultaneous request
  logic            r_port;     // port owning the current transaction
  logic            r_we;
  logic [15:0]     r_addr;
  logic [7:0]      r_wdata;
  logic            r_oe;
  logic [7:0]      r_io_byte;
  logic [7:0]      r_rd_cap;   // read byte held until the done pulse

  state_t          w_ns;
  logic [c_KW-1:0] w_nk;
  logic [c_KW-1:0] w_k_inc;
  logic            w_last;
  logic            w_send;
  logic            w_recv;
  logic            w_nen;
  logic            w_nwe;
  logic            w_nre;
  logic            w_oe;
  logic [15:0]     w_slot_addr;
  logic [7:0]      w_slot_byte;
  logic            w_slot_start;
  logic            w_grant;
  logic            w_pick;

  assign IO = r_oe ? r_io_byte : 8'hzz;

  assign w_last  = (r_k == c_K_LAST);
  assign w_k_inc = w_last ? '0 : r_k + 1'b1;

  // Grant happens only in an idle cycle that is not already the grant cycle.
  assign w_grant = (r_state == ST_IDLE) && (gnt == 2'b00) && (|req);
  assign w_pick  = (req == 2'b11) ? r_prio : req[1];

  // Next slot and phase; the idle grant cycle hands over to UNLOCK1 at k=0.
  always_comb begin
    w_ns = r_state;
    w_nk = '0;
    case (r_state)
      ST_IDLE:    w_ns = (gnt != 2'b00) ? ST_UNLOCK1 : ST_IDLE;
      ST_UNLOCK1: begin w_ns = w_last ? ST_UNLOCK2 : ST_UNLOCK1; w_nk = w_k_inc; end
      ST_UNLOCK2: begin w_ns = w_last ? ST_OPCODE  : ST_UNLOCK2; w_nk = w_k_inc; end
      ST_OPCODE:  begin w_ns = w_last ? ST_ACCESS  : ST_OPCODE;  w_nk = w_k_inc; end
      ST_ACCESS:  begin w_ns = w_last ? ST_FINISH  : ST_ACCESS;  w_nk = w_k_inc; end
      ST_FINISH:  w_ns = ST_IDLE;
      default:    w_ns = ST_IDLE;
    endcase
  end

  // Strobe levels for the upcoming phase, so registered strobes land on schedule.
  always_comb begin
    w_send = 1'b0;
    w_recv = 1'b0;
    case (w_ns)
      ST_UNLOCK1, ST_UNLOCK2, ST_OPCODE: w_send = 1'b1;
      ST_ACCESS: begin
        w_send = r_we;
        w_recv = !r_we;
      end
      default: ;
    endcase
    w_nen = 1'b1;
    w_nwe = 1'b1;
    w_nre = 1'b1;
    w_oe  = 1'b0;
    if (w_send) begin
      w_nen = (w_nk >= c_K_EN_OFF);
      w_nwe = !((w_nk >= c_K_STB_ON) && (w_nk < c_K_CMD));
      w_oe  = (w_nk >= c_K_OE_ON) && (w_nk < c_K_OE_OFF);
    end else if (w_recv) begin
      w_nen = (w_nk >= c_K_CMD);
      w_nre = !((w_nk >= c_K_STB_ON) && (w_nk < c_K_RE_OFF));
    end
  end

  // Address and byte carried by the upcoming slot.
  always_comb begin
    w_slot_addr = 16'h5555;
    w_slot_byte = 8'hAA;
    case (w_ns)
      ST_UNLOCK2: begin
        w_slot_addr = 16'hAAAA;
        w_slot_byte = 8'h55;
      end
      ST_OPCODE:  w_slot_byte = r_we ? 8'h20 : 8'h10;
      ST_ACCESS: begin
        w_slot_addr = r_addr;
        w_slot_byte = r_wdata;
      end
      default: ;
    endcase
    w_slot_start = (w_send || w_recv) && (w_nk == '0);
  end

  // Sequencer state, arbitration and all registered bus outputs.
  always_ff @(posedge clk or posedge bi_rst) begin
    if (bi_rst) begin
      r_state   <= ST_IDLE;
      r_k       <= '0;
      r_prio    <= 1'b0;
      r_port    <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= 16'h0000;
      r_wdata   <= 8'h00;
      r_oe      <= 1'b0;
      r_io_byte <= 8'h00;
      r_rd_cap  <= 8'h00;
      gnt       <= 2'b00;
      done      <= 2'b00;
      rdata     <= 8'h00;
      busy      <= 1'b0;
      nEN       <= 1'b1;
      nRE       <= 1'b1;
      nWE       <= 1'b1;
      Addr      <= 16'h0000;
    end else begin
      r_state <= w_ns;
      r_k     <= w_nk;
      nEN     <= w_nen;
      nWE     <= w_nwe;
      nRE     <= w_nre;
      r_oe    <= w_oe;
      if (w_slot_start) begin
        Addr      <= w_slot_addr;
        r_io_byte <= w_slot_byte;
      end

      gnt <= 2'b00;
      if (w_grant) begin
        gnt     <= w_pick ? 2'b10 : 2'b01;
        r_port  <= w_pick;
        r_prio  <= !w_pick;
        busy    <= 1'b1;
        r_we    <= w_pick ? we[1]  : we[0];
        r_addr  <= w_pick ? addr1  : addr0;
        r_wdata <= w_pick ? wdata1 : wdata0;
      end

      // Flash data is still valid on the edge that raises nRE.
      if (w_recv && (w_nk == c_K_RE_OFF)) begin
        r_rd_cap <= IO;
      end

      done <= 2'b00;
      if (w_ns == ST_FINISH) begin
        done <= r_port ? 2'b10 : 2'b01;
        if (!r_we) begin
          rdata <= r_rd_cap;
        end
      end
      if (r_state == ST_FINISH) begin
        busy <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_flash_bus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flash_bus_sequencer
//  Description : Self-checking bench for flash_bus_sequencer: flash model,
//                protocol monitor and transaction-level scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_flash_bus_sequencer;
    localparam int T_CMD      = 20;
    localparam int T_SETUP    = 10;
    localparam int T_HOLD     = 7;
    localparam int T_DELTA    = 1;
    localparam int TXN_CYCLES = 8 * T_CMD + 1;   // gnt cycle to done cycle

    logic        clk    = 1'b0;
    logic        bi_rst = 1'b0;
    logic [1:0]  req    = 2'b00;
    logic [1:0]  we     = 2'b00;
    logic [15:0] addr0  = 16'h0;
    logic [15:0] addr1  = 16'h0;
    logic [7:0]  wdata0 = 8'h0;
    logic [7:0]  wdata1 = 8'h0;
    wire  [1:0]  gnt;
    wire  [1:0]  done;
    wire  [7:0]  rdata;
    wire         busy;
    wire         nEN;
    wire         nRE;
    wire         nWE;
    wire  [15:0] Addr;
    wire  [7:0]  IO;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input bit ok,
                       input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always #5 clk = ~clk;

    flash_bus_sequencer #(
        .T_CMD(T_CMD), .T_SETUP(T_SETUP), .T_HOLD(T_HOLD), .T_DELTA(T_DELTA)
    ) dut (
        .clk(clk), .bi_rst(bi_rst), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
        .nEN(nEN), .nRE(nRE), .nWE(nWE), .Addr(Addr), .IO(IO)
    );

    // An undriven bus reads back as 8'hFF, which is how "IO = z" is observed.
    for (genvar b = 0; b < 8; b++) begin : g_pu
        pullup (IO[b]);
    end

    // Flash core read model: contents are a fixed function of the address.
    function automatic logic [7:0] flash_rd(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    wire flash_drv = !nEN && !nRE;
    assign IO = flash_drv ? flash_rd(Addr) : 8'hzz;
    wire oe_obs = !flash_drv && (IO !== 8'hFF);

    // ---------------- protocol monitor ----------------
    logic [31:0] wlog[$];   // {Addr, 8'h0, byte} latched at each nWE rise
    logic [15:0] rlog[$];   // Addr at each nRE fall
    logic p_nen = 1'b1, p_nwe = 1'b1, p_nre = 1'b1, p_oe = 1'b0, p_busy = 1'b0;
    logic [7:0] p_io = 8'hFF;
    logic [7:0] hold_byte = 8'h0;
    int io_stable = 0, nwe_low = 0, nre_low = 0, nen_high = 0;
    int slot_idx = 0, hold_left = 0, done_cnt = 0;

    always @(negedge clk) begin : mon
        int changes;
        if (bi_rst) begin
            hold_left = 0; nwe_low = 0; nre_low = 0; nen_high = 0; io_stable = 0;
        end else begin
            changes = int'(nEN !== p_nen) + int'(nWE !== p_nwe) +
                      int'(nRE !== p_nre) + int'(oe_obs !== p_oe);
            if (changes != 0) chk("strobe_sep", changes === 1, changes, 1);
            if (gnt != 2'b00) begin
                chk("gnt_while_busy", p_busy === 1'b0, p_busy, 1'b0);
                slot_idx = 0;
            end
            if (done != 2'b00) done_cnt++;
            if (IO === p_io) io_stable++; else io_stable = 0;
            if (hold_left > 0) begin
                chk("io_hold", IO === hold_byte, IO, hold_byte);
                hold_left--;
            end
            if (!nWE) nwe_low++;
            if (nWE && !p_nwe) begin
                chk("nwe_low_len", nwe_low === (T_CMD - T_DELTA), nwe_low, T_CMD - T_DELTA);
                chk("io_setup", io_stable >= T_SETUP, io_stable, T_SETUP);
                wlog.push_back({Addr, 8'h00, IO});
                hold_byte = IO;
                hold_left = T_HOLD - 1;
                nwe_low   = 0;
            end
            if (!nRE) nre_low++;
            if (!nRE && p_nre) rlog.push_back(Addr);
            if (nRE && !p_nre) begin
                chk("nre_low_len", nre_low === (T_CMD - 2 * T_DELTA), nre_low, T_CMD - 2 * T_DELTA);
                chk("rx_no_oe", IO === 8'hFF, IO, 8'hFF);
                nre_low = 0;
            end
            if (nEN) nen_high++;
            if (!nEN && p_nen) begin
                slot_idx++;
                if (slot_idx > 1)
                    chk("nen_gap", nen_high === (T_CMD - T_DELTA), nen_high, T_CMD - T_DELTA);
                nen_high = 0;
            end
        end
        p_nen = nEN; p_nwe = nWE; p_nre = nRE; p_oe = oe_obs; p_busy = busy; p_io = IO;
    end

    // ---------------- transaction model ----------------
    int last_port = -1;   // -1: nothing granted since reset, port 0 first

    function automatic int pick(input logic [1:0] r, input int last);
        if (r == 2'b11) return (last == 0) ? 1 : 0;
        return r[1] ? 1 : 0;
    endfunction

    task automatic do_txn(input logic [1:0] rq, input bit keep);
        int          p;
        int          n;
        logic        ew;
        logic [15:0] ea;
        logic [7:0]  ed;
        logic [1:0]  oh;
        logic [31:0] w;
        logic [31:0] exp_w;
        p  = pick(rq, last_port);
        ew = we[p];
        ea = (p == 1) ? addr1 : addr0;
        ed = (p == 1) ? wdata1 : wdata0;
        oh = (p == 1) ? 2'b10 : 2'b01;
        req = rq;
        n = 0;
        while (gnt == 2'b00 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("gnt_seen", gnt !== 2'b00, gnt, 1'b1);
        if (gnt == 2'b00) begin
            req = 2'b00;
            return;
        end
        chk("gnt_port", gnt === oh, gnt, oh);
        chk("busy_at_gnt", busy === 1'b1, busy, 1'b1);
        last_port = p;
        wlog.delete();
        rlog.delete();
        if (!keep) req = 2'b00;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done == 2'b00 && n < 400);
        chk("done_latency", n === TXN_CYCLES, n, TXN_CYCLES);
        chk("done_port", done === oh, done, oh);
        chk("busy_at_done", busy === 1'b1, busy, 1'b1);
        chk("send_slots", wlog.size() === (ew ? 4 : 3), wlog.size(), ew ? 4 : 3);
        chk("recv_slots", rlog.size() === (ew ? 0 : 1), rlog.size(), ew ? 0 : 1);
        if (wlog.size() >= 3) begin
            w = wlog[0];
            chk("slot_unlock1", w === 32'h5555_00AA, w, 32'h5555_00AA);
            w = wlog[1];
            chk("slot_unlock2", w === 32'hAAAA_0055, w, 32'hAAAA_0055);
            w = wlog[2];
            exp_w = ew ? 32'h5555_0020 : 32'h5555_0010;
            chk("slot_opcode", w === exp_w, w, exp_w);
        end
        if (ew && wlog.size() == 4) begin
            w = wlog[3];
            exp_w = {ea, 8'h00, ed};
            chk("slot_write", w === exp_w, w, exp_w);
        end
        if (!ew) begin
            if (rlog.size() == 1) chk("read_addr", rlog[0] === ea, rlog[0], ea);
            chk("rdata", rdata === flash_rd(ea), rdata, flash_rd(ea));
        end
        @(negedge clk);
        chk("busy_after", busy === 1'b0, busy, 1'b0);
        chk("done_after", done === 2'b00, done, 2'b00);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin : main
        int n;
        int d0;
        #2 bi_rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_nEN", nEN === 1'b1, nEN, 1'b1);
        chk("rst_nRE", nRE === 1'b1, nRE, 1'b1);
        chk("rst_nWE", nWE === 1'b1, nWE, 1'b1);
        chk("rst_IO", IO === 8'hFF, IO, 8'hFF);
        chk("rst_gnt", gnt === 2'b00, gnt, 2'b00);
        chk("rst_done", done === 2'b00, done, 2'b00);
        chk("rst_busy", busy === 1'b0, busy, 1'b0);
        chk("rst_Addr", Addr === 16'h0000, Addr, 16'h0000);
        chk("rst_rdata", rdata === 8'h00, rdata, 8'h00);
        bi_rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single write on port 0.
        we = 2'b01; addr0 = 16'h1234; wdata0 = 8'h5A;
        do_txn(2'b01, 1'b0);

        // Single read on port 1.
        we = 2'b00; addr1 = 16'h00FF;
        do_txn(2'b10, 1'b0);
        chk("read_C3", rdata === 8'hC3, rdata, 8'hC3);

        // Random mix of ports, ops and contention.
        for (int i = 0; i < 12; i++) begin
            we     = 2'($urandom);
            addr0  = 16'($urandom);
            addr1  = 16'($urandom);
            wdata0 = 8'($urandom_range(0, 254));
            wdata1 = 8'($urandom_range(0, 254));
            do_txn(2'($urandom_range(1, 3)), 1'b0);
        end

        // Continuous contention: grants must alternate.
        for (int i = 0; i < 4; i++) begin
            we     = 2'($urandom);
            addr0  = 16'($urandom);
            addr1  = 16'($urandom);
            wdata0 = 8'($urandom_range(0, 254));
            wdata1 = 8'($urandom_range(0, 254));
            do_txn(2'b11, 1'b1);
        end
        req = 2'b00;
        repeat (2) @(negedge clk);

        // Reset in the middle of a port 0 write, during OPCODE at k=12.
        we = 2'b01; addr0 = 16'hBEEF; wdata0 = 8'h77;
        req = 2'b01;
        n = 0;
        while (gnt == 2'b00 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("mid_gnt", gnt === 2'b01, gnt, 2'b01);
        req = 2'b00;
        repeat (1 + 2 * 2 * T_CMD + 12) @(negedge clk);
        chk("mid_nWE_low", nWE === 1'b0, nWE, 1'b0);
        chk("mid_IO_opcode", IO === 8'h20, IO, 8'h20);
        d0 = done_cnt;
        #1 bi_rst = 1'b1;
        #1;
        chk("mid_rst_nEN", nEN === 1'b1, nEN, 1'b1);
        chk("mid_rst_nWE", nWE === 1'b1, nWE, 1'b1);
        chk("mid_rst_nRE", nRE === 1'b1, nRE, 1'b1);
        chk("mid_rst_IO", IO === 8'hFF, IO, 8'hFF);
        chk("mid_rst_busy", busy === 1'b0, busy, 1'b0);
        chk("mid_rst_Addr", Addr === 16'h0000, Addr, 16'h0000);
        chk("mid_rst_rdata", rdata === 8'h00, rdata, 8'h00);
        repeat (3) @(negedge clk);
        bi_rst = 1'b0;
        last_port = -1;
        repeat (200) @(negedge clk);
        chk("no_done_after_rst", done_cnt === d0, done_cnt, d0);

        // First grant after reset goes to port 0 under contention.
        we = 2'b10; addr0 = 16'h4321; addr1 = 16'h8765; wdata0 = 8'h11; wdata1 = 8'h22;
        do_txn(2'b11, 1'b0);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Safety net against a hung run.
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
